fetch_sequencer: RTL and testbench

Controls the instruction-fetch datapath when instruction memory is multi-cycle, using a req/ack handshake instead of a combinational read.
- Owns the word-address PC.
- Arbitrates redirect sources (register jump, jump, branch) with the same priority as the single-cycle next-PC mux chain.
- Issues imem requests and buffers returned instructions in a small FIFO.
- Decode pops instructions from the FIFO.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_buf.sv | 63 ++++++
 rtl/fetch_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction-fetch sequencer
// Purpose: default widths/reset PC, FSM state encoding and the buffer entry layout.
// Ports: none (package).
package fetch_pkg;

  localparam int DEF_ADDR_W   = 30;
  localparam int DEF_INSTR_W  = 32;
  localparam int DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  // Buffer entry at default widths; the FIFO stores the same {pc, instr} packing.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - small power-of-two FIFO buffering fetched {pc, instr} entries
// Purpose: DEPTH-entry FIFO with push, pop and a synchronous flush that beats both.
// Ports:
//   i_clock, i_reset (async active-low)
//   i_flush  - empty the FIFO on this edge
//   i_push, i_data - write an entry (dropped if full and not popping)
//   i_pop    - drop the head entry (ignored when empty)
//   o_head   - head entry, combinational
//   o_count  - number of valid entries
module fetch_buf #(
  parameter int DEPTH = 2,
  parameter int W     = 62,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [W-1:0]     i_data,
  input  logic             i_pop,
  output logic [W-1:0]     o_head,
  output logic [CNT_W-1:0] o_count
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign w_pop_ok  = i_pop & (r_count != '0) & ~i_flush;
  // A full FIFO can still accept a push when the head leaves on the same edge.
  assign w_push_ok = i_push & ~i_flush & ((r_count != CNT_W'(DEPTH)) | w_pop_ok);

  always_ff @(posedge i_clock) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multi-cycle instruction-fetch sequencer with redirect arbitration
// Purpose: owns the word PC, issues req/ack fetches to imem, buffers responses,
//   and handles jr/jump/branch redirects (jr highest, branch lowest).
// Optional feature macro: FETCH_PERF_EN (perf counters; tied to 0 when undefined).
// Ports:
//   i_clock, i_reset (async active-low)
//   o_imem_req, o_imem_addr, i_imem_ack, i_imem_data     - instruction memory handshake
//   i_jr_valid/i_jr_target, i_jump_valid/i_jump_target,
//   i_branch_taken/i_branch_target                       - redirect sources
//   o_fetch_valid, o_fetch_instr, o_fetch_pc, i_fetch_pop - decode-side buffer head
//   o_perf_fetched, o_perf_squashed                      - performance counters
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int INSTR_W   = DEF_INSTR_W,
  parameter int RESET_PC  = DEF_RESET_PC,
  parameter int BUF_DEPTH = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  output logic               o_imem_req,
  output logic [31:0]        o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [INSTR_W-1:0] i_imem_data,
  input  logic               i_jr_valid,
  input  logic [ADDR_W-1:0]  i_jr_target,
  input  logic               i_jump_valid,
  input  logic [ADDR_W-1:0]  i_jump_target,
  input  logic               i_branch_taken,
  input  logic [ADDR_W-1:0]  i_branch_target,
  output logic               o_fetch_valid,
  output logic [INSTR_W-1:0] o_fetch_instr,
  output logic [ADDR_W-1:0]  o_fetch_pc,
  input  logic               i_fetch_pop,
  output logic [31:0]        o_perf_fetched,
  output logic [31:0]        o_perf_squashed
);

  localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  fetch_state_t        r_state;
  logic [ADDR_W-1:0]   r_pc;      // next word to fetch, or stored redirect target in DRAIN
  logic [ADDR_W-1:0]   r_req_pc;  // address currently presented to imem
  logic                r_imem_req;

  logic                w_redirect;
  logic [ADDR_W-1:0]   w_target;
  logic                w_push;
  logic                w_pop_ok;
  logic [CNT_W-1:0]    w_count;
  logic [CNT_W-1:0]    w_cnt_after;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic [ENTRY_W-1:0]  w_head;

  assign w_redirect = i_jr_valid | i_jump_valid | i_branch_taken;

  always_comb begin
    w_target = i_branch_target;
    if (i_jump_valid) w_target = i_jump_target;
    if (i_jr_valid)   w_target = i_jr_target;
  end

  // A redirect flushes the buffer, so a pop on the same edge must not count.
  assign w_pop_ok    = i_fetch_pop & (w_count != '0) & ~w_redirect;
  assign w_push      = (r_state == ST_FETCH) & i_imem_ack & ~w_redirect;
  assign w_cnt_after = w_count + CNT_W'(1) - CNT_W'(w_pop_ok);
  assign w_pc_inc    = r_pc + ADDR_W'(1);

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .W     (ENTRY_W)
  ) u_buf (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_flush (w_redirect),
    .i_push  (w_push),
    .i_data  ({r_pc, i_imem_data}),
    .i_pop   (w_pop_ok),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= ADDR_W'(RESET_PC);
      r_req_pc   <= ADDR_W'(RESET_PC);
      r_imem_req <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_FETCH;
          r_imem_req <= 1'b1;
          if (w_redirect) begin
            r_pc     <= w_target;
            r_req_pc <= w_target;
          end else begin
            r_req_pc <= r_pc;
          end
        end
        ST_FETCH: begin
          if (w_redirect) begin
            r_pc <= w_target;
            if (i_imem_ack) begin
              r_req_pc <= w_target;
            end else begin
              // Request is still in flight; keep its address until it is acked.
              r_state <= ST_DRAIN;
            end
          end else if (i_imem_ack) begin
            r_pc <= w_pc_inc;
            if (w_cnt_after == CNT_W'(BUF_DEPTH)) begin
              r_state    <= ST_FULL;
              r_imem_req <= 1'b0;
            end else begin
              r_req_pc <= w_pc_inc;
            end
          end
        end
        ST_FULL: begin
          if (w_redirect) begin
            r_state    <= ST_FETCH;
            r_pc       <= w_target;
            r_req_pc   <= w_target;
            r_imem_req <= 1'b1;
          end else if (w_pop_ok) begin
            r_state    <= ST_FETCH;
            r_req_pc   <= r_pc;
            r_imem_req <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // An ack completes the stale request; a redirect on the same edge
          // simply supplies the newest target for the restart.
          if (i_imem_ack) begin
            r_state <= ST_FETCH;
            if (w_redirect) begin
              r_pc     <= w_target;
              r_req_pc <= w_target;
            end else begin
              r_req_pc <= r_pc;
            end
          end else if (w_redirect) begin
            r_pc <= w_target;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_squashed;
  logic        w_squash;

  assign w_squash = i_imem_ack &
                    (((r_state == ST_FETCH) & w_redirect) | (r_state == ST_DRAIN));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_perf_fetched  <= '0;
      r_perf_squashed <= '0;
    end else begin
      if (w_pop_ok) r_perf_fetched  <= r_perf_fetched + 32'd1;
      if (w_squash) r_perf_squashed <= r_perf_squashed + 32'd1;
    end
  end

  assign o_perf_fetched  = r_perf_fetched;
  assign o_perf_squashed = r_perf_squashed;
`else
  assign o_perf_fetched  = 32'd0;
  assign o_perf_squashed = 32'd0;
`endif

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = 32'({r_req_pc, 2'b00});
  assign o_fetch_valid = (w_count != '0);
  assign o_fetch_pc    = w_head[ENTRY_W-1 -: ADDR_W];
  assign o_fetch_instr = w_head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        jr_valid;
  logic [29:0] jr_target;
  logic        jump_valid;
  logic [29:0] jump_target;
  logic        branch_taken;
  logic [29:0] branch_target;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [29:0] fetch_pc;
  logic        fetch_pop;
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;

  int checks   = 0;
  int failures = 0;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .i_clock         (clk),
    .i_reset         (rst_n),
    .o_imem_req      (imem_req),
    .o_imem_addr     (imem_addr),
    .i_imem_ack      (imem_ack),
    .i_imem_data     (imem_data),
    .i_jr_valid      (jr_valid),
    .i_jr_target     (jr_target),
    .i_jump_valid    (jump_valid),
    .i_jump_target   (jump_target),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .o_fetch_valid   (fetch_valid),
    .o_fetch_instr   (fetch_instr),
    .o_fetch_pc      (fetch_pc),
    .i_fetch_pop     (fetch_pop),
    .o_perf_fetched  (perf_fetched),
    .o_perf_squashed (perf_squashed)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pexp(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  initial begin
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_data = '0;
    jr_valid = 1'b0; jr_target = '0;
    jump_valid = 1'b0; jump_target = '0;
    branch_taken = 1'b0; branch_target = '0;
    fetch_pop = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", fetch_valid, 0);
    chk("rst_perf_f", perf_fetched, 0);
    chk("rst_perf_s", perf_squashed, 0);

    // 1. Fetch 0x0, 0x4 with ack every cycle, buffer fills
    rst_n = 1'b1;
    #1 chk("idle_req", imem_req, 0);
    @(negedge clk);
    chk("t1_req0", imem_req, 1);
    chk("t1_addr0", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_data = 32'hA000_0000;
    @(negedge clk);
    chk("t1_addr1", imem_addr, 32'h4);
    chk("t1_valid", fetch_valid, 1);
    chk("t1_pc0", fetch_pc, 30'h0);
    chk("t1_instr0", fetch_instr, 32'hA000_0000);
    imem_data = 32'hA000_0001;
    @(negedge clk);
    chk("t1_full_req", imem_req, 0);
    chk("t1_full_pc", fetch_pc, 30'h0);
    imem_ack = 1'b0; fetch_pop = 1'b1;
    @(negedge clk);
    chk("t1_pop_pc", fetch_pc, 30'h1);
    chk("t1_pop_instr", fetch_instr, 32'hA000_0001);
    chk("t1_resume_req", imem_req, 1);
    chk("t1_resume_addr", imem_addr, 32'h8);

    // Advance pc to 5 with ack+pop pairs (count stays 1)
    imem_ack = 1'b1; imem_data = 32'hA000_0002;
    @(negedge clk);
    imem_data = 32'hA000_0003;
    @(negedge clk);
    imem_data = 32'hA000_0004;
    @(negedge clk);
    chk("t2_addr5", imem_addr, 32'h14);
    chk("t2_head_pc", fetch_pc, 30'h4);
    chk("t2_perf_f", perf_fetched, pexp(4));

    // 2. jump + branch together, ack 3 cycles later
    imem_ack = 1'b0; fetch_pop = 1'b0;
    jump_valid = 1'b1; jump_target = 30'h40;
    branch_taken = 1'b1; branch_target = 30'h10;
    @(negedge clk);
    jump_valid = 1'b0; branch_taken = 1'b0;
    chk("t2_drain_req", imem_req, 1);
    chk("t2_drain_addr", imem_addr, 32'h14);
    chk("t2_flushed", fetch_valid, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t2_hold_addr", imem_addr, 32'h14);
    imem_ack = 1'b1; imem_data = 32'hDEAD_0000;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("t2_new_addr", imem_addr, 32'h100);
    chk("t2_discard", fetch_valid, 0);
    chk("t2_perf_s", perf_squashed, pexp(1));

    // 3. jr with same-cycle ack
    jr_valid = 1'b1; jr_target = 30'h3;
    imem_ack = 1'b1; imem_data = 32'hDEAD_0001;
    @(negedge clk);
    jr_valid = 1'b0; imem_ack = 1'b0;
    chk("t3_addr", imem_addr, 32'hC);
    chk("t3_empty", fetch_valid, 0);
    chk("t3_perf_s", perf_squashed, pexp(2));
    // Pop while empty is ignored
    fetch_pop = 1'b1;
    @(negedge clk);
    fetch_pop = 1'b0;
    chk("t3_pop_empty", fetch_valid, 0);
    chk("t3_perf_f", perf_fetched, pexp(4));

    // 4. Fill buffer, then pop + branch in the same cycle
    imem_ack = 1'b1; imem_data = 32'hB000_0003;
    @(negedge clk);
    chk("t4_addr", imem_addr, 32'h10);
    chk("t4_head_pc", fetch_pc, 30'h3);
    imem_data = 32'hB000_0004;
    @(negedge clk);
    chk("t4_full_req", imem_req, 0);
    imem_ack = 1'b0; fetch_pop = 1'b1;
    branch_taken = 1'b1; branch_target = 30'h20;
    @(negedge clk);
    fetch_pop = 1'b0; branch_taken = 1'b0;
    chk("t4_flushed", fetch_valid, 0);
    chk("t4_addr80", imem_addr, 32'h80);
    chk("t4_req", imem_req, 1);
    chk("t4_perf_f", perf_fetched, pexp(4));

    // 5. pc wrap at 0x3FFFFFFF
    jr_valid = 1'b1; jr_target = 30'h3FFF_FFFF;
    imem_ack = 1'b1; imem_data = 32'hDEAD_0002;
    @(negedge clk);
    jr_valid = 1'b0;
    chk("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
    imem_data = 32'hC000_0009;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("t5_wrap_addr", imem_addr, 32'h0);
    chk("t5_head_pc", fetch_pc, 30'h3FFF_FFFF);
    chk("t5_head_instr", fetch_instr, 32'hC000_0009);
    chk("t5_perf_s", perf_squashed, pexp(3));

    // 6. Reset asserted while in DRAIN
    jump_valid = 1'b1; jump_target = 30'h100;
    @(negedge clk);
    jump_valid = 1'b0;
    chk("t6_drain_req", imem_req, 1);
    chk("t6_drain_addr", imem_addr, 32'h0);
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_req", imem_req, 0);
    chk("t6_rst_perf_s", perf_squashed, 0);
    @(negedge clk);
    chk("t6_rst_valid", fetch_valid, 0);
    rst_n = 1'b1;
    #1 chk("t6_idle_req", imem_req, 0);
    @(negedge clk);
    chk("t6_restart_req", imem_req, 1);
    chk("t6_restart_addr", imem_addr, 32'h0);
    chk("t6_perf_f", perf_fetched, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
